line_delay_buffer: RTL and testbench



---
 rtl/line_delay_buffer_pkg.sv | 25 ++
 rtl/sdp_ram_read_first.sv | 56 +++++
 rtl/line_delay_buffer.sv | 129 ++++++++++++
 tb/tb_line_delay_buffer.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/line_delay_buffer_pkg.sv
// Shared helpers for the line delay buffer: constant-width math used to size
// column counters and RAM addresses at elaboration time.
package line_delay_buffer_pkg;

    localparam int MIN_LINE_LENGTH = 2;
    localparam int MAX_ADDR_BITS   = 31;

    // Ceiling log2, bounded loop so it stays a legal constant function.
    function automatic int clog2(input int value);
        int width;
        width = 0;
        for (int b = 0; b < MAX_ADDR_BITS; b++) begin
            if ((1 << width) < value) begin
                width = width + 1;
            end
        end
        return width;
    endfunction

    // Address width that never collapses to zero bits.
    function automatic int addr_width(input int depth);
        return (clog2(depth) < 1) ? 1 : clog2(depth);
    endfunction

endpackage

// File: rtl/sdp_ram_read_first.sv
// Single-port read-first RAM with registered read and an optional second
// output register; coded in the shape block-RAM inference expects.
module sdp_ram_read_first
    import line_delay_buffer_pkg::*;
#(
    parameter int DATA_WIDTH = 256,
    parameter int RAM_DEPTH  = 640,
    parameter bit OUT_REG    = 1'b1,
    parameter int ADDR_W     = addr_width(RAM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en_i,
    input  logic [ADDR_W-1:0]     addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [RAM_DEPTH];
    logic [DATA_WIDTH-1:0] rd_q;

    // Contents are never reset so the array maps onto a RAM primitive.
    always_ff @(posedge clk) begin
        if (en_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    // Read samples the pre-write contents of the addressed word.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q <= '0;
        end else if (en_i) begin
            rd_q <= mem_q[addr_i];
        end
    end

    generate
        if (OUT_REG) begin : g_out_reg
            logic [DATA_WIDTH-1:0] out_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    out_q <= '0;
                end else begin
                    out_q <= rd_q;
                end
            end

            assign rdata_o = out_q;
        end else begin : g_no_out_reg
            assign rdata_o = rd_q;
        end
    endgenerate

endmodule

// File: rtl/line_delay_buffer.sv
// Row-delay line: returns, for each accepted pixel, the word written at the
// same column one line earlier, with column and first-line tracking.
module line_delay_buffer
    import line_delay_buffer_pkg::*;
#(
    parameter int DATA_WIDTH   = 256,
    parameter int LINE_LENGTH  = 640,
    parameter int READ_LATENCY = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic                          in_sof,
    input  logic [DATA_WIDTH-1:0]         in_data,
    output logic                          out_valid,
    output logic                          out_prev_valid,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic [clog2(LINE_LENGTH)-1:0] out_col
);

    localparam int COL_W  = clog2(LINE_LENGTH);
    localparam int STAGES = (READ_LATENCY == 1) ? 1 : 2;
    localparam logic [COL_W-1:0] LAST_COL     = COL_W'(LINE_LENGTH - 1);
    localparam logic [COL_W-1:0] SOF_NEXT_COL = COL_W'(1);

    generate
        if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
            $error("line_delay_buffer: READ_LATENCY must be 1 or 2");
        end
        if (LINE_LENGTH < MIN_LINE_LENGTH) begin : g_bad_length
            $error("line_delay_buffer: LINE_LENGTH must be at least 2");
        end
    endgenerate

    logic [COL_W-1:0] col_q, col_d;
    logic             first_line_q, first_line_d;
    logic [COL_W-1:0] acc_col;
    logic             acc_prev;
    logic             ram_en;

    // A start-of-frame pixel is forced onto column 0 of a fresh line 0,
    // which also overrides a wrap happening in the same cycle.
    always_comb begin
        col_d        = col_q;
        first_line_d = first_line_q;
        acc_col      = col_q;
        acc_prev     = ~first_line_q;
        if (in_valid) begin
            if (in_sof) begin
                acc_col      = '0;
                acc_prev     = 1'b0;
                col_d        = SOF_NEXT_COL;
                first_line_d = 1'b1;
            end else if (col_q == LAST_COL) begin
                col_d        = '0;
                first_line_d = 1'b0;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q        <= '0;
            first_line_q <= 1'b1;
        end else begin
            col_q        <= col_d;
            first_line_q <= first_line_d;
        end
    end

    assign ram_en = in_valid & ~rst;

    sdp_ram_read_first #(
        .DATA_WIDTH (DATA_WIDTH),
        .RAM_DEPTH  (LINE_LENGTH),
        .OUT_REG    (READ_LATENCY == 2),
        .ADDR_W     (COL_W)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .en_i    (ram_en),
        .addr_i  (acc_col),
        .wdata_i (in_data),
        .rdata_o (out_data)
    );

    logic             pipe_valid_q [STAGES];
    logic             pipe_prev_q  [STAGES];
    logic [COL_W-1:0] pipe_col_q   [STAGES];

    // Side-band pipeline matches the RAM read path stage for stage.
    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_pipe
            if (gi == 0) begin : g_head
                always_ff @(posedge clk) begin
                    if (rst) begin
                        pipe_valid_q[gi] <= 1'b0;
                        pipe_prev_q[gi]  <= 1'b0;
                        pipe_col_q[gi]   <= '0;
                    end else begin
                        pipe_valid_q[gi] <= in_valid;
                        pipe_prev_q[gi]  <= acc_prev;
                        pipe_col_q[gi]   <= acc_col;
                    end
                end
            end else begin : g_tail
                always_ff @(posedge clk) begin
                    if (rst) begin
                        pipe_valid_q[gi] <= 1'b0;
                        pipe_prev_q[gi]  <= 1'b0;
                        pipe_col_q[gi]   <= '0;
                    end else begin
                        pipe_valid_q[gi] <= pipe_valid_q[gi-1];
                        pipe_prev_q[gi]  <= pipe_prev_q[gi-1];
                        pipe_col_q[gi]   <= pipe_col_q[gi-1];
                    end
                end
            end
        end
    endgenerate

    assign out_valid      = pipe_valid_q[STAGES-1];
    assign out_prev_valid = pipe_prev_q[STAGES-1];
    assign out_col        = pipe_col_q[STAGES-1];

endmodule

// File: tb/tb_line_delay_buffer.sv
// Directed bench: drives one stimulus stream into a latency-2 and a latency-1
// instance and checks both against hand-derived per-pixel expectations.
module tb_line_delay_buffer;

    typedef struct packed {
        logic       v;
        logic       pv;
        logic [3:0] d;
        logic [2:0] col;
    } exp_t;

    localparam exp_t IDLE = '0;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_sof = 1'b0;
    logic [3:0] in_data = '0;

    logic       rl2_valid, rl2_prev;
    logic [3:0] rl2_data;
    logic [2:0] rl2_col;
    logic       rl1_valid, rl1_prev;
    logic [3:0] rl1_data;
    logic [2:0] rl1_col;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    exp_t exp1 = IDLE;
    exp_t exp2 = IDLE;
    exp_t pend2 = IDLE;

    always #5 clk = ~clk;

    line_delay_buffer #(
        .DATA_WIDTH   (4),
        .LINE_LENGTH  (5),
        .READ_LATENCY (2)
    ) u_dut_rl2 (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_sof         (in_sof),
        .in_data        (in_data),
        .out_valid      (rl2_valid),
        .out_prev_valid (rl2_prev),
        .out_data       (rl2_data),
        .out_col        (rl2_col)
    );

    line_delay_buffer #(
        .DATA_WIDTH   (4),
        .LINE_LENGTH  (5),
        .READ_LATENCY (1)
    ) u_dut_rl1 (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_sof         (in_sof),
        .in_data        (in_data),
        .out_valid      (rl1_valid),
        .out_prev_valid (rl1_prev),
        .out_data       (rl1_data),
        .out_col        (rl1_col)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
        checks++;
        if (obs !== req) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, obs, req);
        end
    endtask

    function automatic exp_t mk(input logic pv, input logic [3:0] d, input logic [2:0] col);
        exp_t e;
        e.v   = 1'b1;
        e.pv  = pv;
        e.d   = d;
        e.col = col;
        return e;
    endfunction

    task automatic compare_dut(input string name, input logic ov, input logic opv,
                               input logic [3:0] od, input logic [2:0] oc, input exp_t e);
        check({name, ".valid"}, 32'(ov), 32'(e.v));
        if (e.v) begin
            check({name, ".col"}, 32'(oc), 32'(e.col));
            check({name, ".prev_valid"}, 32'(opv), 32'(e.pv));
            if (e.pv) begin
                check({name, ".data"}, 32'(od), 32'(e.d));
            end
        end
    endtask

    // One clock of stimulus; e is what this pixel must produce on the outputs.
    task automatic cycle(input logic r, input logic v, input logic s,
                         input logic [3:0] d, input exp_t e);
        rst      = r;
        in_valid = v;
        in_sof   = s;
        in_data  = d;
        @(posedge clk);
        #1;
        cyc++;
        if (r) begin
            exp1  = IDLE;
            exp2  = IDLE;
            pend2 = IDLE;
        end else begin
            exp2  = pend2;
            pend2 = e;
            exp1  = e;
        end
        $display("cyc=%0d rst=%0b v=%0b sof=%0b d=%0h | rl1 v=%0b pv=%0b col=%0d d=%0h | rl2 v=%0b pv=%0b col=%0d d=%0h",
                 cyc, r, v, s, d, rl1_valid, rl1_prev, rl1_col, rl1_data,
                 rl2_valid, rl2_prev, rl2_col, rl2_data);
        compare_dut("rl1", rl1_valid, rl1_prev, rl1_data, rl1_col, exp1);
        compare_dut("rl2", rl2_valid, rl2_prev, rl2_data, rl2_col, exp2);
        if (r) begin
            check("rst.rl1.prev_valid", 32'(rl1_prev), 32'd0);
            check("rst.rl1.col",        32'(rl1_col),  32'd0);
            check("rst.rl1.data",       32'(rl1_data), 32'd0);
            check("rst.rl2.prev_valid", 32'(rl2_prev), 32'd0);
            check("rst.rl2.col",        32'(rl2_col),  32'd0);
            check("rst.rl2.data",       32'(rl2_data), 32'd0);
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            cycle(1'b0, 1'b0, 1'b0, 4'h0, IDLE);
        end
    endtask

    initial begin
        // Reset state.
        cycle(1'b1, 1'b0, 1'b0, 4'h0, IDLE);
        cycle(1'b1, 1'b0, 1'b0, 4'h0, IDLE);

        // sof + 10 continuous pixels: line 1 returns 0..4 at columns 0..4.
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 1'b1, 1'(i == 0), 4'(i), mk(1'(i >= 5), 4'(i - 5), 3'(i % 5)));
        end
        idle(2);

        // Same stream with a gap after every pixel; gap data must not be stored.
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 1'b1, 1'(i == 0), 4'(i), mk(1'(i >= 5), 4'(i - 5), 3'(i % 5)));
            cycle(1'b0, 1'b0, 1'b0, 4'hF, IDLE);
        end
        idle(2);

        // 15 pixels with a second sof on pixel 7: line restarts there.
        for (int i = 0; i < 15; i++) begin
            int base;
            int k;
            base = (i < 7) ? 0 : 7;
            k    = i - base;
            cycle(1'b0, 1'b1, 1'(i == 0 || i == 7), 4'(i),
                  mk(1'(k >= 5), 4'(i - 5), 3'(k % 5)));
        end
        idle(2);

        // Reset mid-line after pixel 3, with in_valid held high during reset.
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b1, 1'(i == 0), 4'(i), mk(1'b0, 4'h0, 3'(i)));
        end
        cycle(1'b1, 1'b1, 1'b0, 4'hF, IDLE);
        for (int j = 0; j < 6; j++) begin
            cycle(1'b0, 1'b1, 1'b0, 4'(8 + j), mk(1'(j >= 5), 4'(8 + j - 5), 3'(j % 5)));
        end
        idle(2);

        // Read-first: column 2 gets A, B, C on lines 0..2; others get the line index.
        for (int i = 0; i < 15; i++) begin
            int line;
            int c;
            int d;
            int ed;
            line = i / 5;
            c    = i % 5;
            d    = (c == 2) ? (10 + line) : line;
            ed   = (c == 2) ? (10 + line - 1) : (line - 1);
            cycle(1'b0, 1'b1, 1'(i == 0), 4'(d), mk(1'(line >= 1), 4'(ed), 3'(c)));
        end
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
